// File: rtl/mvp_transform_ctrl_pkg.sv
// Shared definitions for the MVP transform sequencer: state encoding,
// bus widths and the row/column element packing used on every 512-bit matrix bus.
package mvp_transform_ctrl_pkg;

  localparam int MAT_W = 512;
  localparam int VEC_W = 128;
  localparam logic [31:0] FP_ONE = 32'h3F800000;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PV_ISSUE,
    S_PV_WAIT,
    S_MVP_ISSUE,
    S_MVP_WAIT,
    S_READY,
    S_VTX_ISSUE,
    S_VTX_WAIT,
    S_OUT
  } state_t;

  // Bit offset of element (r,c), r and c counted from 1.
  function automatic int idx(input int r, input int c);
    return 32 * (4 * (r - 1) + (c - 1));
  endfunction

endpackage

// File: rtl/mvp_transform_ctrl.sv
// Sequences the shared 4x4 multiplier: builds MVP = P*V*M once per configuration,
// then pushes each vertex through it in vector mode behind a valid/ready handshake.
module mvp_transform_ctrl
  import mvp_transform_ctrl_pkg::*;
#(
  parameter int VCNT_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_load,
  output logic              cfg_ready,
  input  logic [MAT_W-1:0]  mat_model,
  input  logic [MAT_W-1:0]  mat_view,
  input  logic [MAT_W-1:0]  mat_proj,
  output logic              mvp_valid,
  input  logic              vin_valid,
  output logic              vin_ready,
  input  logic [VEC_W-1:0]  vin_data,
  output logic              vout_valid,
  input  logic              vout_ready,
  output logic [VEC_W-1:0]  vout_data,
  output logic [VCNT_W-1:0] vtx_count,
  output logic              mm_start,
  output logic              mm_mult_vec,
  output logic [MAT_W-1:0]  mm_m,
  output logic [MAT_W-1:0]  mm_v,
  input  logic [MAT_W-1:0]  mm_o,
  input  logic              mm_done
);

  localparam int E11 = idx(1, 1);
  localparam int E21 = idx(2, 1);
  localparam int E31 = idx(3, 1);
  localparam int E41 = idx(4, 1);

  state_t state, next_state;

  logic [MAT_W-1:0] model_q, view_q, proj_q, pv, mvp;
  logic [VEC_W-1:0] vtx_q;
  logic [MAT_W-1:0] vtx_col;

  logic cfg_accept, vtx_accept;

  assign cfg_accept = cfg_load && (state == S_IDLE || state == S_READY);
  assign vtx_accept = (state == S_READY) && mvp_valid && vin_valid && !cfg_load;

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:      if (cfg_load) next_state = S_PV_ISSUE;
      S_PV_ISSUE:  next_state = S_PV_WAIT;
      S_PV_WAIT:   if (mm_done) next_state = S_MVP_ISSUE;
      S_MVP_ISSUE: next_state = S_MVP_WAIT;
      S_MVP_WAIT:  if (mm_done) next_state = S_READY;
      S_READY: begin
        if (cfg_load)        next_state = S_PV_ISSUE;
        else if (vtx_accept) next_state = S_VTX_ISSUE;
      end
      S_VTX_ISSUE: next_state = S_VTX_WAIT;
      S_VTX_WAIT:  if (mm_done) next_state = S_OUT;
      S_OUT:       if (vout_ready) next_state = S_READY;
      default:     next_state = S_IDLE;
    endcase
  end

  // Vertex occupies column 1 of the right operand; every other element stays zero.
  always_comb begin
    vtx_col = '0;
    vtx_col[E11 +: 32] = vtx_q[31:0];
    vtx_col[E21 +: 32] = vtx_q[63:32];
    vtx_col[E31 +: 32] = vtx_q[95:64];
    vtx_col[E41 +: 32] = vtx_q[127:96];
  end

  // Operands depend only on registered state and holding registers, so they
  // cannot move between the start pulse and the multiplier finishing.
  always_comb begin
    mm_start    = 1'b0;
    mm_mult_vec = 1'b0;
    mm_m        = '0;
    mm_v        = '0;
    cfg_ready   = (state == S_IDLE) || (state == S_READY);
    vin_ready   = (state == S_READY) && mvp_valid;
    unique case (state)
      S_PV_ISSUE, S_PV_WAIT: begin
        mm_start = (state == S_PV_ISSUE);
        mm_m     = proj_q;
        mm_v     = view_q;
      end
      S_MVP_ISSUE, S_MVP_WAIT: begin
        mm_start = (state == S_MVP_ISSUE);
        mm_m     = pv;
        mm_v     = model_q;
      end
      S_VTX_ISSUE, S_VTX_WAIT: begin
        mm_start    = (state == S_VTX_ISSUE);
        mm_mult_vec = 1'b1;
        mm_m        = mvp;
        mm_v        = vtx_col;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      model_q    <= '0;
      view_q     <= '0;
      proj_q     <= '0;
      pv         <= '0;
      mvp        <= '0;
      vtx_q      <= '0;
      mvp_valid  <= 1'b0;
      vout_valid <= 1'b0;
      vout_data  <= '0;
      vtx_count  <= '0;
    end else begin
      if (cfg_accept) begin
        model_q   <= mat_model;
        view_q    <= mat_view;
        proj_q    <= mat_proj;
        mvp_valid <= 1'b0;
      end
      if (vtx_accept) vtx_q <= vin_data;
      if (state == S_PV_WAIT && mm_done) pv <= mm_o;
      if (state == S_MVP_WAIT && mm_done) begin
        mvp       <= mm_o;
        mvp_valid <= 1'b1;
      end
      if (state == S_VTX_WAIT && mm_done) begin
        vout_data  <= {mm_o[E41 +: 32], mm_o[E31 +: 32], mm_o[E21 +: 32], mm_o[E11 +: 32]};
        vout_valid <= 1'b1;
      end
      if (state == S_OUT && vout_ready) begin
        vout_valid <= 1'b0;
        vtx_count  <= vtx_count + VCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mvp_transform_ctrl.sv
// Bench for mvp_transform_ctrl: a behavioural float multiplier stands in for
// mat_mult4D, and a scoreboard checks every delivered vertex against hand values.
module tb_mvp_transform_ctrl;

  localparam int VCNT_W = 16;
  localparam logic [127:0] VTX_1231  = {32'h3F800000, 32'h40400000, 32'h40000000, 32'h3F800000};
  localparam logic [127:0] EXP_TRANS = {32'h3F800000, 32'h40400000, 32'h40000000, 32'h40C00000};
  localparam logic [127:0] EXP_DIAG  = {32'h3F800000, 32'h40C00000, 32'h40800000, 32'h40000000};

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              cfg_load = 1'b0;
  logic              cfg_ready;
  logic [511:0]      mat_model = '0, mat_view = '0, mat_proj = '0;
  logic              mvp_valid;
  logic              vin_valid = 1'b0;
  logic              vin_ready;
  logic [127:0]      vin_data = '0;
  logic              vout_valid;
  logic              vout_ready = 1'b0;
  logic [127:0]      vout_data;
  logic [VCNT_W-1:0] vtx_count;
  logic              mm_start, mm_mult_vec;
  logic [511:0]      mm_m, mm_v;
  logic [511:0]      mm_o = '0;
  logic              mm_done = 1'b1;

  int checks = 0;
  int errors = 0;
  int start_count = 0;
  logic [127:0] exp_q[$];

  always #5 clock = ~clock;

  mvp_transform_ctrl #(.VCNT_W(VCNT_W)) dut (
    .clock(clock), .reset(reset), .cfg_load(cfg_load), .cfg_ready(cfg_ready),
    .mat_model(mat_model), .mat_view(mat_view), .mat_proj(mat_proj),
    .mvp_valid(mvp_valid), .vin_valid(vin_valid), .vin_ready(vin_ready),
    .vin_data(vin_data), .vout_valid(vout_valid), .vout_ready(vout_ready),
    .vout_data(vout_data), .vtx_count(vtx_count), .mm_start(mm_start),
    .mm_mult_vec(mm_mult_vec), .mm_m(mm_m), .mm_v(mm_v), .mm_o(mm_o),
    .mm_done(mm_done)
  );

  task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  function automatic int tidx(input int r, input int c);
    return 32 * (4 * (r - 1) + (c - 1));
  endfunction

  function automatic real f2r(input logic [31:0] b);
    real r;
    int  e;
    if (b[30:0] == 31'd0) return 0.0;
    e = int'(b[30:23]) - 127;
    r = 1.0 + real'(b[22:0]) / 8388608.0;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return b[31] ? -r : r;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] de;
    if (r == 0.0) return 32'h0;
    d  = $realtobits(r);
    de = d[62:52] - 11'd896;
    return {d[63], de[7:0], d[51:29]};
  endfunction

  function automatic logic [511:0] matmul(input logic [511:0] a, input logic [511:0] b);
    logic [511:0] o;
    real acc;
    o = '0;
    for (int r = 1; r <= 4; r++)
      for (int c = 1; c <= 4; c++) begin
        acc = 0.0;
        for (int k = 1; k <= 4; k++)
          acc = acc + f2r(a[tidx(r, k) +: 32]) * f2r(b[tidx(k, c) +: 32]);
        o[tidx(r, c) +: 32] = r2f(acc);
      end
    return o;
  endfunction

  function automatic logic [511:0] mat_ident();
    logic [511:0] m;
    m = '0;
    for (int i = 1; i <= 4; i++) m[tidx(i, i) +: 32] = 32'h3F800000;
    return m;
  endfunction

  // Behavioural stand-in for the shared multiplier, with nominal latencies.
  logic [511:0] cap_m, cap_v;
  logic         cap_vec;
  int           mm_cnt;
  always @(posedge clock) begin
    if (reset) begin
      mm_done <= 1'b1;
      mm_o    <= '0;
      mm_cnt  <= 0;
    end else if (mm_start) begin
      check_output("start_while_busy", 128'(mm_done), 128'd1);
      start_count <= start_count + 1;
      cap_m   <= mm_m;
      cap_v   <= mm_v;
      cap_vec <= mm_mult_vec;
      mm_done <= 1'b0;
      mm_cnt  <= mm_mult_vec ? 37 : 85;
    end else if (!mm_done) begin
      if (mm_cnt == 1) begin
        check_output("operand_stable", 128'({mm_m == cap_m, mm_v == cap_v, mm_mult_vec == cap_vec}), 128'b111);
        mm_o    <= matmul(cap_m, cap_v);
        mm_done <= 1'b1;
      end
      mm_cnt <= mm_cnt - 1;
    end
  end

  // Scoreboard monitor: compares at every output handshake.
  always @(negedge clock) begin
    if (!reset && vout_valid && vout_ready) begin
      check_output("scoreboard_nonempty", 128'(exp_q.size() != 0), 128'd1);
      if (exp_q.size() != 0) check_output("vout_data", vout_data, exp_q.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic wait_mvp();
    int budget = 400;
    while (!mvp_valid && budget > 0) begin tick(1); budget--; end
    check_output("mvp_valid_after_config", 128'(mvp_valid), 128'd1);
  endtask

  task automatic wait_count(input int target);
    int budget = 300;
    while (vtx_count != VCNT_W'(target) && budget > 0) begin tick(1); budget--; end
    check_output("vtx_count", 128'(vtx_count), 128'(target));
  endtask

  task automatic configure(input logic [511:0] m, input logic [511:0] v, input logic [511:0] p);
    int budget = 300;
    while (!cfg_ready && budget > 0) begin tick(1); budget--; end
    check_output("cfg_ready_before_load", 128'(cfg_ready), 128'd1);
    mat_model = m; mat_view = v; mat_proj = p;
    cfg_load = 1'b1;
    tick(1);
    cfg_load = 1'b0;
    wait_mvp();
  endtask

  task automatic apply_stimulus(input logic [127:0] vtx, input logic [127:0] expected);
    int budget = 300;
    while (!vin_ready && budget > 0) begin tick(1); budget--; end
    check_output("vin_ready_before_send", 128'(vin_ready), 128'd1);
    exp_q.push_back(expected);
    vin_data  = vtx;
    vin_valid = 1'b1;
    tick(1);
    vin_valid = 1'b0;
  endtask

  initial begin
    logic [511:0] ident, trans, diag;
    logic [127:0] held;
    int s0, budget, bad_data, bad_ready, bad_start;

    ident = mat_ident();
    trans = ident;
    trans[tidx(1, 4) +: 32] = 32'h40A00000;
    diag = ident;
    diag[tidx(1, 1) +: 32] = 32'h40000000;
    diag[tidx(2, 2) +: 32] = 32'h40000000;
    diag[tidx(3, 3) +: 32] = 32'h40000000;

    tick(3);
    reset = 1'b0;
    check_output("reset_cfg_ready",  128'(cfg_ready),  128'd1);
    check_output("reset_mvp_valid",  128'(mvp_valid),  128'd0);
    check_output("reset_vin_ready",  128'(vin_ready),  128'd0);
    check_output("reset_vout_valid", 128'(vout_valid), 128'd0);
    check_output("reset_vtx_count",  128'(vtx_count),  128'd0);
    check_output("reset_mm_start",   128'(mm_start),   128'd0);

    // Identity everywhere: vertex passes through, three multiplies in total.
    vout_ready = 1'b1;
    configure(ident, ident, ident);
    apply_stimulus(VTX_1231, VTX_1231);
    wait_count(1);
    check_output("identity_start_pulses", 128'(start_count), 128'd3);

    configure(trans, ident, ident);
    apply_stimulus(VTX_1231, EXP_TRANS);
    wait_count(2);

    configure(ident, ident, diag);
    apply_stimulus(VTX_1231, EXP_DIAG);
    wait_count(3);

    // Backpressure: output must hold with no new work issued.
    vout_ready = 1'b0;
    apply_stimulus(VTX_1231, EXP_DIAG);
    budget = 200;
    while (!vout_valid && budget > 0) begin tick(1); budget--; end
    check_output("bp_vout_valid", 128'(vout_valid), 128'd1);
    held = vout_data;
    bad_data = 0; bad_ready = 0; bad_start = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (vout_data !== held || !vout_valid) bad_data++;
      if (vin_ready) bad_ready++;
      if (mm_start) bad_start++;
    end
    check_output("bp_data_stable", 128'(bad_data), 128'd0);
    check_output("bp_vin_ready_low", 128'(bad_ready), 128'd0);
    check_output("bp_no_start", 128'(bad_start), 128'd0);
    check_output("bp_count_held", 128'(vtx_count), 128'd3);
    vout_ready = 1'b1;
    wait_count(4);
    tick(2);
    check_output("bp_single_increment", 128'(vtx_count), 128'd4);

    // cfg_load during a vertex multiply is dropped.
    s0 = start_count;
    apply_stimulus(VTX_1231, EXP_DIAG);
    tick(2);
    check_output("vtx_wait_cfg_ready", 128'(cfg_ready), 128'd0);
    mat_model = ident; mat_view = ident; mat_proj = ident;
    cfg_load = 1'b1;
    tick(1);
    cfg_load = 1'b0;
    wait_count(5);
    check_output("dropped_cfg_starts", 128'(start_count - s0), 128'd1);
    check_output("dropped_cfg_mvp_valid", 128'(mvp_valid), 128'd1);

    // cfg_load beats vin_valid in the same cycle.
    budget = 100;
    while (!vin_ready && budget > 0) begin tick(1); budget--; end
    s0 = start_count;
    vin_data = VTX_1231;
    cfg_load = 1'b1;
    vin_valid = 1'b1;
    tick(1);
    cfg_load = 1'b0;
    vin_valid = 1'b0;
    check_output("reconf_vin_ready", 128'(vin_ready), 128'd0);
    check_output("reconf_mvp_cleared", 128'(mvp_valid), 128'd0);
    wait_mvp();
    check_output("reconf_starts", 128'(start_count - s0), 128'd2);
    check_output("reconf_count_held", 128'(vtx_count), 128'd5);
    apply_stimulus(VTX_1231, VTX_1231);
    wait_count(6);

    // Reset in the middle of the P*V multiply.
    mat_model = trans;
    cfg_load = 1'b1;
    tick(1);
    cfg_load = 1'b0;
    tick(4);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check_output("midreset_mvp_valid", 128'(mvp_valid), 128'd0);
    check_output("midreset_cfg_ready", 128'(cfg_ready), 128'd1);
    check_output("midreset_mm_start",  128'(mm_start),  128'd0);
    check_output("midreset_vtx_count", 128'(vtx_count), 128'd0);
    configure(trans, ident, ident);
    apply_stimulus(VTX_1231, EXP_TRANS);
    wait_count(1);

    tick(5);
    check_output("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
